// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM states and sizing helper for the bit-serial arithmetic blocks
package serial_arith_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit difference/borrow cell
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state, nxt;
    logic [WIDTH-1:0] sa, sb, sd, sd_next;
    logic [CW-1:0]    count;
    logic             borrow, d, bo, last;

    full_subtractor u_fs (
        .x (sa[0]),
        .y (sb[0]),
        .bi(borrow),
        .d (d),
        .bo(bo)
    );

    assign last        = count == CW'(WIDTH - 1);
    assign sd_next     = {d, sd[WIDTH-1:1]};
    assign start_ready = state == IDLE;
    assign done_valid  = state == DONE;
    assign busy        = state != IDLE;

    always_comb begin
        nxt = state;
        if (state == IDLE && start_valid) nxt = SHIFT;
        else if (state == SHIFT && last) nxt = DONE;
        else if (state == DONE && done_ready) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    // diff/bout are only written at the last shift so they hold across DONE and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (state == IDLE && start_valid) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            count  <= '0;
        end else if (state == SHIFT) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            sd     <= sd_next;
            borrow <= bo;
            count  <= count + CW'(1);
            if (last) begin
                diff <= sd_next;
                bout <= bo;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for an 8-bit instance plus a 4-bit exhaustive sweep
module tb_serial_subtractor;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sv8, sr8, bin8, bo8, dv8, dr8, busy8;
    logic [7:0] a8, b8, d8;
    logic       sv4, sr4, bin4, bo4, dv4, dr4, busy4;
    logic [3:0] a4, b4, d4;
    int         checks = 0, errors = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .bin(bin8), .diff(d8), .bout(bo8),
        .done_valid(dv8), .done_ready(dr8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .a(a4), .b(b4), .bin(bin4), .diff(d4), .bout(bo4),
        .done_valid(dv4), .done_ready(dr4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input bit scramble, input int hold);
        int         k;
        logic [8:0] e;
        logic [7:0] held;
        @(negedge clk);
        chk("op8_start_ready", sr8, 1'b1);
        a8 = av; b8 = bv; bin8 = bi; sv8 = 1'b1;
        @(posedge clk);
        q8.push_back({1'b0, av} - {1'b0, bv} - {8'd0, bi});
        #1;
        sv8 = 1'b0;
        dr8 = hold == 0;
        chk("op8_busy", busy8, 1'b1);
        chk("op8_ready_low", sr8, 1'b0);
        k = 0;
        while (!dv8 && k < 40) begin
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            sv8 = hold > 0 && k == 2;
            if (sv8) a8 = 8'h10;
            @(posedge clk);
            #1;
            k++;
        end
        sv8 = 1'b0;
        chk("op8_latency", k, 8);
        chk("op8_sb_size", q8.size(), 1);
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("op8_diff", d8, e[7:0]);
            chk("op8_bout", bo8, e[8]);
        end
        held = d8;
        repeat (hold) begin
            sv8 = 1'b1; a8 = 8'h10;
            @(posedge clk);
            #1;
            chk("bp_done_valid", dv8, 1'b1);
            chk("bp_diff_stable", d8, held);
            chk("bp_start_ready", sr8, 1'b0);
        end
        sv8 = 1'b0;
        dr8 = 1'b1;
        @(posedge clk);
        #1;
        chk("op8_release", dv8, 1'b0);
        chk("op8_idle_ready", sr8, 1'b1);
        chk("op8_diff_hold", d8, held);
    endtask

    initial begin
        int         k;
        bit         seen;
        time        tprev;
        logic [4:0] e4;
        sv8 = 0; a8 = 0; b8 = 0; bin8 = 0; dr8 = 1;
        sv4 = 0; a4 = 0; b4 = 0; bin4 = 0; dr4 = 1;
        #12;
        chk("rst_start_ready", sr8, 1'b1);
        chk("rst_diff", d8, 8'h00);
        chk("rst_bout", bo8, 1'b0);
        chk("rst_done_valid", dv8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0, 0, 0);
        op8(8'h03, 8'h05, 1'b0, 0, 0);
        op8(8'h00, 8'h00, 1'b1, 0, 0);
        op8(8'hFF, 8'hFF, 1'b0, 0, 0);
        op8(8'hC3, 8'h41, 1'b1, 0, 5);
        op8(8'h80, 8'h01, 1'b0, 0, 0);
        op8(8'hA5, 8'h5A, 1'b0, 1, 0);

        // abort after three shift cycles; the aborted op never enters the scoreboard
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; sv8 = 1'b1;
        @(posedge clk);
        #1;
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_diff", d8, 8'h00);
        chk("mid_rst_bout", bo8, 1'b0);
        chk("mid_rst_done_valid", dv8, 1'b0);
        chk("mid_rst_busy", busy8, 1'b0);
        chk("mid_rst_start_ready", sr8, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen |= dv8;
        end
        chk("mid_rst_no_done", seen, 1'b0);
        op8(8'h20, 8'h21, 1'b0, 0, 0);

        tprev = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            k = 0;
            while (!sr4 && k < 20) begin
                @(negedge clk);
                k++;
            end
            a4 = 4'(i >> 5); b4 = 4'(i >> 1); bin4 = i[0]; sv4 = 1'b1;
            @(posedge clk);
            q4.push_back({1'b0, a4} - {1'b0, b4} - {4'd0, bin4});
            if (i > 0) chk("sweep_spacing", ($time - tprev) / 10, 6);
            tprev = $time;
            #1;
            sv4 = 1'b0;
            k = 0;
            while (!dv4 && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("sweep_latency", k, 4);
            chk("sweep_sb_size", q4.size(), 1);
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                chk("sweep_diff", d4, e4[3:0]);
                chk("sweep_bout", bo4, e4[4]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. It computes diff = a - b - bin, one bit per clock, LSB first.
- A single registered 1-bit full-subtractor cell carries a borrow flip-flop between bits.
- Valid/ready handshakes sit on both the operand side and the result side.
- It is the subtracting counterpart of the team's combinational full adder, for area-constrained datapaths where a WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands a/b/bin are valid
- start_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend, sampled on start handshake
- b  input  WIDTH  subtrahend, sampled on start handshake
- bin  input  1  borrow-in, sampled on start handshake
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)
- done_valid  output  1  diff/bout valid
- done_ready  input  1  consumer accepts result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; diff = 0; bout = 0; done_valid = 0; busy = 0.
  - Borrow flip-flop, bit counter and shift registers all cleared.
  - start_ready = (state == IDLE), so it reads 1 during and after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready at edge T: capture a→sa, b→sb, bin→borrow; count = 0; go to SHIFT.
- SHIFT, each edge:
  - d = sa[0] ^ sb[0] ^ borrow.
  - borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - sa, sb shift right by 1; result shift register sd shifts right with d inserted at MSB; count increments.
  - On the edge where count == WIDTH-1: load diff = final sd (including this bit), bout = borrow_next, done_valid = 1, go to DONE.
- Latency: start handshake at edge T → done_valid high after edge T+WIDTH, i.e. exactly WIDTH SHIFT cycles.
- DONE:
  - done_valid = 1; diff and bout are held stable.
  - On done_valid & done_ready: done_valid = 0, go to IDLE.
  - diff and bout keep their last value until the next DONE entry; they are not cleared on a new start.
- start_ready is 0 in SHIFT and DONE. start_valid outside IDLE is ignored; no queuing.
- Completion and start cannot overlap: the minimum period between starts is WIDTH+2 cycles (WIDTH SHIFT, 1 DONE, 1 IDLE).
- count width is $clog2(WIDTH+1). Arithmetic is unsigned modulo 2^WIDTH.
- Reset mid-operation (SHIFT or DONE): abort immediately, clear all outputs, no done_valid pulse. The first operation after reset behaves as a clean start.
- Operand inputs may change freely after the start handshake without affecting the result.

Decomposition:
- Shared package serial_arith_pkg:
  - state enum (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2);
  - localparam function for the counter width.
- Sub-module full_subtractor: combinational 1-bit cell, ports (x, y, bi) → (d, bo), instantiated once.
- Borrow flip-flop, shift registers, counter and FSM live in serial_subtractor.

Test Plan:
- WIDTH=8; a=0x05, b=0x03, bin=0 → done_valid exactly 8 cycles after the handshake edge; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 → diff=0x00, bout=0.
- Back-pressure: hold done_ready=0 for 5 cycles in DONE → done_valid stays 1, diff/bout stable, start_ready=0. A start_valid pulse with a=0x10 during SHIFT/DONE is ignored. After done_ready=1, the next op 0x80-0x01 → diff=0x7F, bout=0.
- Operand change: after the handshake with a=0xA5, b=0x5A, drive a/b to random values every cycle → diff=0x4B, bout=0.
- Reset mid-SHIFT: assert rst_n=0 for 1 cycle after 3 SHIFT cycles → all outputs 0, start_ready=1, no done_valid. Next op 0x20-0x21 → diff=0xFF, bout=1.
- Exhaustive sweep at WIDTH=4 (all a, b, bin with done_ready tied 1) → every result matches the a-b-bin model. Back-to-back ops are spaced WIDTH+2 cycles apart.
